// File: rtl/fd2s_seq_pkg.sv
// Shared definitions for the fd2s_seq streaming double-to-single packer:
// controller state encoding and conversion constants.
package fd2s_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Double bias (1023) minus single bias (127).
  localparam int unsigned BIAS_DIFF   = 896;
  localparam logic [7:0]  SGL_INF_EXP = 8'hFF;
  localparam logic [31:0] PAD_WORD    = 32'h0;
  localparam logic [10:0] DBL_INF_EXP = 11'h7FF;

endpackage

// File: rtl/fd2s_seq_fd2s.sv
// fd2s: combinational IEEE double -> single converter, truncating (no rounding).
// Exception flag outputs exist only when FD2S_SEQ_FLAGS_EN is defined.
module fd2s
  import fd2s_seq_pkg::*;
(
  input  logic [63:0] a,
  output logic [31:0] y
`ifdef FD2S_SEQ_FLAGS_EN
  ,
  output logic        ovf,
  output logic        unf,
  output logic        nan
`endif
);

  logic        sign;
  logic [10:0] dexp;

  assign sign = a[63];
  assign dexp = a[62:52];

  // Classify the double exponent and build the single-precision result.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    y = {sign, 31'h0};
`ifdef FD2S_SEQ_FLAGS_EN
    ovf = 1'b0;
    unf = 1'b0;
    nan = 1'b0;
`endif
    if (dexp == DBL_INF_EXP) begin
      y = {sign, SGL_INF_EXP, a[51:29]};
`ifdef FD2S_SEQ_FLAGS_EN
      nan = |a[51:0];
`endif
    end else if (dexp == 11'd0) begin
`ifdef FD2S_SEQ_FLAGS_EN
      unf = |a[51:0];
`endif
    end else if (dexp <= 11'(BIAS_DIFF)) begin
`ifdef FD2S_SEQ_FLAGS_EN
      unf = 1'b1;
`endif
    end else if (dexp >= 11'(BIAS_DIFF + 255)) begin
      y = {sign, SGL_INF_EXP, 23'h0};
`ifdef FD2S_SEQ_FLAGS_EN
      ovf = 1'b1;
`endif
    end else begin
      y = {sign, 8'(dexp - 11'(BIAS_DIFF)), a[51:29]};
    end
  end

endmodule

// File: rtl/fd2s_seq.sv
// fd2s_seq: converts a job of `count` doubles to singles and packs them two
// per 64-bit output word (first element in the low half). An odd trailing
// element is flushed with a zero upper half. Optional macro
// FD2S_SEQ_FLAGS_EN adds a sticky per-job flags[2:0] = {nan, ovf, unf} output.
module fd2s_seq
  import fd2s_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  input  logic             i_valid,
  input  logic [63:0]      i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [63:0]      o_data,
  input  logic             o_ready
`ifdef FD2S_SEQ_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining;
  logic             toggle;
  logic [31:0]      low_half;
  logic [31:0]      conv_y;
  logic             out_free;
  logic             start_job;
  logic             accept;
  logic             load_pair;
  logic             load_flush;

`ifdef FD2S_SEQ_FLAGS_EN
  logic conv_ovf, conv_unf, conv_nan;
`endif

  fd2s u_fd2s (
    .a   (i_data),
    .y   (conv_y)
`ifdef FD2S_SEQ_FLAGS_EN
    ,
    .ovf (conv_ovf),
    .unf (conv_unf),
    .nan (conv_nan)
`endif
  );

  assign out_free = !o_valid || o_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    start_job  = 1'b0;
    accept     = 1'b0;
    load_pair  = 1'b0;
    load_flush = 1'b0;
    i_ready    = 1'b0;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_job = 1'b1;
          state_d   = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        i_ready   = (remaining != '0) && out_free;
        accept    = i_ready && i_valid;
        load_pair = accept && toggle;
        if (remaining == '0) begin
          if (toggle)        state_d = FLUSH;
          else if (out_free) state_d = DONE;
        end
      end
      FLUSH: begin
        if (toggle) begin
          load_flush = out_free;
        end else if (out_free) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job counter, pair toggle, holding register and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so o_data reads 0 after reset
      // rather than stale contents from an aborted job.
      remaining <= '0;
      toggle    <= 1'b0;
      low_half  <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
    end else begin
      if (start_job) begin
        remaining <= count;
        toggle    <= 1'b0;
      end
      if (accept) begin
        remaining <= remaining - CNT_W'(1);
        toggle    <= !toggle;
        if (!toggle) low_half <= conv_y;
        else         o_data   <= {conv_y, low_half};
      end
      if (load_flush) begin
        o_data <= {PAD_WORD, low_half};
        toggle <= 1'b0;
      end
      if (load_pair || load_flush) o_valid <= 1'b1;
      else if (o_ready)            o_valid <= 1'b0;
    end
  end

`ifdef FD2S_SEQ_FLAGS_EN
  // Sticky exception flags, cleared when a job starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (start_job) begin
      flags <= 3'b000;
    end else if (accept) begin
      flags <= flags | {conv_nan, conv_ovf, conv_unf};
    end
  end
`endif

endmodule
